// File: rtl/watch_time_keeper_if.sv
// Bundle of signals exchanged between the time keeper and its clients
// (set mode drives the load request side, display/set mode read the time).
interface watch_time_keeper_if;
  logic        hold;
  logic        load_req;
  logic [47:0] bin_time;
  logic        load_ack;
  logic        load_err;
  logic [7:0]  year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic        day_tick;

  // Requester / time consumer side
  modport master (
    output hold, load_req, bin_time,
    input  load_ack, load_err, year, month, day, hour, minute, second, day_tick
  );

  // Time keeper side
  modport slave (
    input  hold, load_req, bin_time,
    output load_ack, load_err, year, month, day, hour, minute, second, day_tick
  );
endinterface

// File: rtl/watch_time_keeper.sv
// Watch time keeper: owns the running calendar time, advances it once per
// clk1sec edge with a full second->year carry chain (leap years included),
// and accepts clamped time loads through a level req/ack handshake.
module watch_time_keeper #(
  parameter logic [7:0] YEAR_MAX  = 8'd199,
  parameter logic [7:0] RST_YEAR  = 8'd24,
  parameter logic [7:0] RST_MONTH = 8'd1,
  parameter logic [7:0] RST_DAY   = 8'd1
) (
  input  logic                 clk1sec,
  input  logic                 rst,
  watch_time_keeper_if.slave   bus
);

  typedef enum logic {ST_RUN, ST_ACK} state_t;

  state_t     r_state;
  logic [7:0] r_year, r_month, r_day, r_hour, r_minute, r_second;
  logic       r_load_ack, r_load_err, r_day_tick;

  // Year 0 is 2000 (leap); year 100 is 2100 (not leap).
  function automatic logic is_leap(input logic [7:0] yr);
    return (yr[1:0] == 2'b00) && (yr != 8'd100);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] mon,
                                               input logic [7:0] yr);
    logic [7:0] dim;
    case (mon)
      8'd4, 8'd6, 8'd9, 8'd11: dim = 8'd30;
      8'd2:                    dim = is_leap(yr) ? 8'd29 : 8'd28;
      default:                 dim = 8'd31;
    endcase
    return dim;
  endfunction

  // Saturate into [lo, hi]; plain 8-bit unsigned compares, no wrap.
  function automatic logic [7:0] sat_range(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
    logic [7:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r;
  endfunction

  logic [7:0] w_dim;
  logic [7:0] w_inc_year, w_inc_month, w_inc_day;
  logic [7:0] w_inc_hour, w_inc_minute, w_inc_second;
  logic       w_rollover;

  logic [7:0] w_ld_year, w_ld_month, w_ld_day;
  logic [7:0] w_ld_hour, w_ld_minute, w_ld_second;
  logic [7:0] w_ld_dim;
  logic       w_ld_err;

  assign w_dim = days_in_month(r_month, r_year);

  // Next time value for a normal one-second advance, with the carry chain.
  always_comb begin
    w_inc_year   = r_year;
    w_inc_month  = r_month;
    w_inc_day    = r_day;
    w_inc_hour   = r_hour;
    w_inc_minute = r_minute;
    w_inc_second = r_second + 8'd1;
    w_rollover   = 1'b0;
    if (r_second >= 8'd59) begin
      w_inc_second = 8'd0;
      w_inc_minute = r_minute + 8'd1;
      if (r_minute >= 8'd59) begin
        w_inc_minute = 8'd0;
        w_inc_hour   = r_hour + 8'd1;
        if (r_hour >= 8'd23) begin
          w_inc_hour = 8'd0;
          w_rollover = 1'b1;
          w_inc_day  = r_day + 8'd1;
          if (r_day >= w_dim) begin
            w_inc_day   = 8'd1;
            w_inc_month = r_month + 8'd1;
            if (r_month >= 8'd12) begin
              w_inc_month = 8'd1;
              w_inc_year  = (r_year >= YEAR_MAX) ? 8'd0 : r_year + 8'd1;
            end
          end
        end
      end
    end
  end

  // Clamp each loaded field; day is bounded by the clamped month/year.
  always_comb begin
    w_ld_year   = sat_range(bus.bin_time[47:40], 8'd0, YEAR_MAX);
    w_ld_month  = sat_range(bus.bin_time[39:32], 8'd1, 8'd12);
    w_ld_dim    = days_in_month(w_ld_month, w_ld_year);
    w_ld_day    = sat_range(bus.bin_time[31:24], 8'd1, w_ld_dim);
    w_ld_hour   = sat_range(bus.bin_time[23:16], 8'd0, 8'd23);
    w_ld_minute = sat_range(bus.bin_time[15:8],  8'd0, 8'd59);
    w_ld_second = sat_range(bus.bin_time[7:0],   8'd0, 8'd59);
    w_ld_err    = (w_ld_year   != bus.bin_time[47:40]) ||
                  (w_ld_month  != bus.bin_time[39:32]) ||
                  (w_ld_day    != bus.bin_time[31:24]) ||
                  (w_ld_hour   != bus.bin_time[23:16]) ||
                  (w_ld_minute != bus.bin_time[15:8])  ||
                  (w_ld_second != bus.bin_time[7:0]);
  end

  // RUN/ACK sequencer: load capture, handshake release, and time advance.
  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_year     <= RST_YEAR;
      r_month    <= RST_MONTH;
      r_day      <= RST_DAY;
      r_hour     <= 8'd0;
      r_minute   <= 8'd0;
      r_second   <= 8'd0;
      r_load_ack <= 1'b0;
      r_load_err <= 1'b0;
      r_day_tick <= 1'b0;
    end else begin
      r_day_tick <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (bus.load_req) begin
            r_year     <= w_ld_year;
            r_month    <= w_ld_month;
            r_day      <= w_ld_day;
            r_hour     <= w_ld_hour;
            r_minute   <= w_ld_minute;
            r_second   <= w_ld_second;
            r_load_ack <= 1'b1;
            r_load_err <= w_ld_err;
            r_state    <= ST_ACK;
          end else if (!bus.hold) begin
            r_year     <= w_inc_year;
            r_month    <= w_inc_month;
            r_day      <= w_inc_day;
            r_hour     <= w_inc_hour;
            r_minute   <= w_inc_minute;
            r_second   <= w_inc_second;
            r_day_tick <= w_rollover;
          end
        end
        ST_ACK: begin
          // Time stays frozen until the requester drops its request.
          if (!bus.load_req) begin
            r_load_ack <= 1'b0;
            r_load_err <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.year     = r_year;
  assign bus.month    = r_month;
  assign bus.day      = r_day;
  assign bus.hour     = r_hour;
  assign bus.minute   = r_minute;
  assign bus.second   = r_second;
  assign bus.load_ack = r_load_ack;
  assign bus.load_err = r_load_err;
  assign bus.day_tick = r_day_tick;

endmodule

// File: tb/tb_watch_time_keeper.sv
// Scoreboard bench for watch_time_keeper: stimulus pushes expected output
// snapshots, a monitor pops and compares them after each clk1sec edge and
// after an asynchronous reset assertion.
module tb_watch_time_keeper;

  typedef struct packed {
    logic [7:0] y, mo, d, h, mi, s;
    logic       ack, err, tick;
  } exp_t;

  logic clk1sec;
  logic rst;
  watch_time_keeper_if bus ();

  watch_time_keeper #(
    .YEAR_MAX (8'd199),
    .RST_YEAR (8'd24),
    .RST_MONTH(8'd1),
    .RST_DAY  (8'd1)
  ) dut (
    .clk1sec(clk1sec),
    .rst    (rst),
    .bus    (bus)
  );

  exp_t  q_exp[$];
  string q_name[$];
  int    n_checks = 0;
  int    n_errors = 0;

  initial clk1sec = 1'b0;
  always #5 clk1sec = ~clk1sec;

  function automatic exp_t mk(input int y, input int mo, input int d,
                              input int h, input int mi, input int s,
                              input logic ack, input logic err,
                              input logic tick);
    exp_t e;
    e.y = 8'(y); e.mo = 8'(mo); e.d = 8'(d);
    e.h = 8'(h); e.mi = 8'(mi); e.s = 8'(s);
    e.ack = ack; e.err = err; e.tick = tick;
    return e;
  endfunction

  function automatic logic [47:0] bt(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(posedge clk1sec or negedge rst);
      #1;
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        a  = {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second,
              bus.load_ack, bus.load_err, bus.day_tick};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL %s: got %0d-%0d-%0d %0d:%0d:%0d ack=%b err=%b tick=%b, expected %0d-%0d-%0d %0d:%0d:%0d ack=%b err=%b tick=%b",
                   nm, a.y, a.mo, a.d, a.h, a.mi, a.s, a.ack, a.err, a.tick,
                   e.y, e.mo, e.d, e.h, e.mi, e.s, e.ack, e.err, e.tick);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Drive one edge's inputs (from a negedge), optionally queue the expected
  // post-edge outputs, then return at the following negedge.
  task automatic step(input logic lr, input logic hd, input logic [47:0] t,
                      input bit chk, input string nm, input exp_t e);
    bus.load_req = lr;
    bus.hold     = hd;
    bus.bin_time = t;
    if (chk) begin
      q_exp.push_back(e);
      q_name.push_back(nm);
    end
    @(posedge clk1sec);
    @(negedge clk1sec);
  endtask

  // Capture edge followed by a release edge; fields stay at the loaded value.
  task automatic load(input logic [47:0] t, input exp_t ld, input string nm);
    exp_t rel;
    step(1'b1, 1'b0, t, 1'b1, {nm, "_capture"}, ld);
    rel = ld;
    rel.ack = 1'b0;
    rel.err = 1'b0;
    step(1'b0, 1'b0, t, 1'b1, {nm, "_release"}, rel);
  endtask

  initial begin
    rst          = 1'b0;
    bus.hold     = 1'b0;
    bus.load_req = 1'b0;
    bus.bin_time = '0;
    @(negedge clk1sec);

    // Reset state holds while rst is low, even across edges.
    step(1'b0, 1'b0, '0, 1'b0, "", '0);
    step(1'b0, 1'b0, '0, 1'b1, "reset_state", mk(24,1,1,0,0,0,0,0,0));
    rst = 1'b1;

    // Free running count: 61 seconds.
    for (int i = 1; i <= 61; i++)
      step(1'b0, 1'b0, '0, 1'b1, "count", mk(24,1,1,0,i/60,i%60,0,0,0));

    // Day rollover into March on a non-leap year.
    load(bt(23,2,28,23,59,59), mk(23,2,28,23,59,59,1,0,0), "ld_2023feb28");
    step(1'b0, 1'b0, '0, 1'b1, "roll_nonleap", mk(23,3,1,0,0,0,0,0,1));
    step(1'b0, 1'b0, '0, 1'b1, "tick_clear",   mk(23,3,1,0,0,1,0,0,0));

    // Leap year: Feb 28 -> Feb 29.
    load(bt(24,2,28,23,59,59), mk(24,2,28,23,59,59,1,0,0), "ld_2024feb28");
    step(1'b0, 1'b0, '0, 1'b1, "roll_leap", mk(24,2,29,0,0,0,0,0,1));

    // 2100 is not leap.
    load(bt(100,2,28,23,59,59), mk(100,2,28,23,59,59,1,0,0), "ld_2100feb28");
    step(1'b0, 1'b0, '0, 1'b1, "roll_2100", mk(100,3,1,0,0,0,0,0,1));

    // Year wrap at YEAR_MAX.
    load(bt(199,12,31,23,59,59), mk(199,12,31,23,59,59,1,0,0), "ld_yearmax");
    step(1'b0, 1'b0, '0, 1'b1, "year_wrap", mk(0,1,1,0,0,0,0,0,1));

    // Clamping of every field; month 0 -> 1, so day bound is 31.
    load(bt(250,0,40,30,77,60), mk(199,1,31,23,59,59,1,1,0), "ld_clamp_all");
    load(bt(23,2,29,10,0,0),    mk(23,2,28,10,0,0,1,1,0),    "ld_clamp_feb");
    load(bt(0,2,29,10,0,0),     mk(0,2,29,10,0,0,1,0,0),     "ld_y2000_feb29");
    load(bt(100,2,29,10,0,0),   mk(100,2,28,10,0,0,1,1,0),   "ld_y2100_feb29");
    load(bt(25,4,31,0,0,0),     mk(25,4,30,0,0,0,1,1,0),     "ld_apr31");
    load(bt(25,13,0,5,5,5),     mk(25,12,1,5,5,5,1,1,0),     "ld_mon13_day0");

    // Handshake: request held for 3 edges keeps time frozen and ack high.
    step(1'b1, 1'b0, bt(24,6,15,12,30,0), 1'b1, "hs_cap",   mk(24,6,15,12,30,0,1,0,0));
    step(1'b1, 1'b0, bt(24,6,15,12,30,0), 1'b1, "hs_hold1", mk(24,6,15,12,30,0,1,0,0));
    step(1'b1, 1'b0, bt(24,6,15,12,30,0), 1'b1, "hs_hold2", mk(24,6,15,12,30,0,1,0,0));
    step(1'b0, 1'b0, '0, 1'b1, "hs_drop",   mk(24,6,15,12,30,0,0,0,0));
    step(1'b0, 1'b0, '0, 1'b1, "hs_resume", mk(24,6,15,12,30,1,0,0,0));

    // hold freezes counting for 5 edges.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, '0, 1'b1, "hold_freeze", mk(24,6,15,12,30,1,0,0,0));
    step(1'b0, 1'b0, '0, 1'b1, "hold_release", mk(24,6,15,12,30,2,0,0,0));

    // Load beats hold; no counting after release while hold stays high.
    step(1'b1, 1'b1, bt(24,6,15,1,2,3), 1'b1, "hold_load_cap", mk(24,6,15,1,2,3,1,0,0));
    step(1'b0, 1'b1, '0, 1'b1, "hold_load_rel",   mk(24,6,15,1,2,3,0,0,0));
    step(1'b0, 1'b1, '0, 1'b1, "hold_load_still", mk(24,6,15,1,2,3,0,0,0));

    // Asynchronous reset in the middle of ACK.
    step(1'b1, 1'b0, bt(30,7,4,8,9,10), 1'b1, "pre_rst_cap", mk(30,7,4,8,9,10,1,0,0));
    #2;
    q_exp.push_back(mk(24,1,1,0,0,0,0,0,0));
    q_name.push_back("async_rst");
    rst = 1'b0;
    #2;
    rst = 1'b1;
    // Request still high after reset: captured again on the first edge.
    step(1'b1, 1'b0, bt(30,7,4,8,9,10), 1'b1, "post_rst_cap", mk(30,7,4,8,9,10,1,0,0));
    step(1'b0, 1'b0, '0, 1'b1, "post_rst_rel", mk(30,7,4,8,9,10,0,0,0));
    step(1'b0, 1'b0, '0, 1'b1, "post_rst_cnt", mk(30,7,4,8,9,11,0,0,0));

    // Every queued expectation must have been consumed.
    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q_exp.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
